// File: rtl/branch_history_predictor.sv
// Purpose : 2-bit saturating-counter branch history table with post-reset init walk; optional stats via BP_STATS_EN.
// Latency : prediction and mispredict flag are combinational (0 cycles); training lands at the next rising clk edge.
// Backpressure: none; bp_busy is high for 2**IDX_W cycles after reset while the table is walked, predictions forced 0.
module branch_history_predictor #(
    parameter int         IDX_W    = 6,
    parameter int         XLEN     = 32,
    parameter logic [1:0] INIT_CNT = 2'b01
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            f_valid,
    input  logic [XLEN-1:0] f_pc,
    output logic            f_pred_taken,
    input  logic            e_valid,
    input  logic            e_branch,
    input  logic [XLEN-1:0] e_pc,
    input  logic            e_btaken,
    input  logic            e_pred_taken,
    output logic            e_mispredict,
    output logic            bp_busy
`ifdef BP_STATS_EN
    ,
    input  logic            stat_clr,
    output logic [31:0]     stat_branches,
    output logic [31:0]     stat_mispredicts
`endif
);

    localparam int               DEPTH    = 1 << IDX_W;
    localparam logic [IDX_W-1:0] LAST_PTR = '1;

    localparam logic [0:0] ST_INIT = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    logic [0:0]       state;
    logic [IDX_W-1:0] init_ptr;
    logic [1:0]       cnt [DEPTH];

    logic [IDX_W-1:0] idx_f;
    logic [IDX_W-1:0] idx_e;
    logic [1:0]       cnt_e;
    logic [1:0]       cnt_next;
    logic             upd;

    // Word-aligned PCs: low two bits never select an entry.
    assign idx_f = f_pc[IDX_W+1:2];
    assign idx_e = e_pc[IDX_W+1:2];

    // Upper PC bits are deliberately ignored (aliasing, no tags).
    logic unused_pc_bits;
    assign unused_pc_bits = ^{f_pc[XLEN-1:IDX_W+2], f_pc[1:0], e_pc[XLEN-1:IDX_W+2], e_pc[1:0]};

    assign bp_busy = (state == ST_INIT);
    assign upd     = (state == ST_RUN) & e_valid & e_branch;

    // Prediction is the counter MSB, suppressed while the table holds garbage.
    assign f_pred_taken = f_valid & ~bp_busy & cnt[idx_f][1];

    // Flag stays live during INIT (pipeline still flushes); held low only under reset.
    assign e_mispredict = reset_n & e_valid & e_branch & (e_btaken != e_pred_taken);

    // Saturating next value for the EX-indexed counter.
    always_comb begin
        cnt_e    = cnt[idx_e];
        cnt_next = cnt_e;
        if (e_btaken) begin
            if (cnt_e != 2'b11) cnt_next = cnt_e + 2'b01;
        end else begin
            if (cnt_e != 2'b00) cnt_next = cnt_e - 2'b01;
        end
    end

    // Init walk sequencing; reset restarts the walk from entry 0.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= ST_INIT;
            init_ptr <= '0;
        end else if (state == ST_INIT) begin
            init_ptr <= init_ptr + 1'b1;
            if (init_ptr == LAST_PTR) state <= ST_RUN;
        end
    end

    // Counter array: init writes during the walk, training afterwards; no reset on storage.
    always_ff @(posedge clk) begin
        if (state == ST_INIT) begin
            cnt[init_ptr] <= INIT_CNT;
        end else if (upd) begin
            cnt[idx_e] <= cnt_next;
        end
    end

`ifdef BP_STATS_EN
    // Event counters; clear dominates a same-cycle increment, wrap naturally.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stat_branches    <= '0;
            stat_mispredicts <= '0;
        end else if (stat_clr) begin
            stat_branches    <= '0;
            stat_mispredicts <= '0;
        end else begin
            if (upd) stat_branches <= stat_branches + 32'd1;
            if ((state == ST_RUN) & e_mispredict) stat_mispredicts <= stat_mispredicts + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_branch_history_predictor.sv
// Bench for branch_history_predictor: directed scenarios plus random traffic
// compared against a table-of-integers model with an init countdown.
// Stats checks are compiled in only when BP_STATS_EN is defined.
module tb_branch_history_predictor;

    logic        clk;
    logic        reset_n;
    logic        f_valid;
    logic [31:0] f_pc;
    logic        f_pred_taken;
    logic        e_valid;
    logic        e_branch;
    logic [31:0] e_pc;
    logic        e_btaken;
    logic        e_pred_taken;
    logic        e_mispredict;
    logic        bp_busy;
    logic        stat_clr;
`ifdef BP_STATS_EN
    logic [31:0] stat_branches;
    logic [31:0] stat_mispredicts;
`endif

    branch_history_predictor #(.IDX_W(6), .XLEN(32), .INIT_CNT(2'b01)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .f_valid      (f_valid),
        .f_pc         (f_pc),
        .f_pred_taken (f_pred_taken),
        .e_valid      (e_valid),
        .e_branch     (e_branch),
        .e_pc         (e_pc),
        .e_btaken     (e_btaken),
        .e_pred_taken (e_pred_taken),
        .e_mispredict (e_mispredict),
        .bp_busy      (bp_busy)
`ifdef BP_STATS_EN
        ,
        .stat_clr         (stat_clr),
        .stat_branches    (stat_branches),
        .stat_mispredicts (stat_mispredicts)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: counter values 0..3 per entry, cycles of init remaining.
    int          model_cnt [64];
    int          init_left;
    int unsigned m_branches;
    int unsigned m_mispredicts;

    int n_chk;
    int n_pass;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    endtask

    function automatic int idx_of(input logic [31:0] pc);
        return int'((pc >> 2) % 64);
    endfunction

    // Drive one cycle: set inputs, check outputs mid-cycle, then advance the model at the edge.
    task automatic step(input logic fv, input logic [31:0] fpc, input logic ev, input logic eb,
                        input logic [31:0] epc, input logic bt, input logic pt);
        logic busy_exp;
        logic pred_exp;
        logic mis_exp;
        int   ie;
        f_valid = fv; f_pc = fpc; e_valid = ev; e_branch = eb; e_pc = epc;
        e_btaken = bt; e_pred_taken = pt;
        @(negedge clk);
        busy_exp = (init_left > 0);
        pred_exp = fv && !busy_exp && (model_cnt[idx_of(fpc)] >= 2);
        mis_exp  = ev && eb && (bt != pt);
        chk("bp_busy", {31'd0, bp_busy}, {31'd0, busy_exp});
        chk("f_pred_taken", {31'd0, f_pred_taken}, {31'd0, pred_exp});
        chk("e_mispredict", {31'd0, e_mispredict}, {31'd0, mis_exp});
`ifdef BP_STATS_EN
        chk("stat_branches", stat_branches, m_branches);
        chk("stat_mispredicts", stat_mispredicts, m_mispredicts);
`endif
        @(posedge clk);
        if (stat_clr) begin
            m_branches = 0; m_mispredicts = 0;
        end else if (!busy_exp) begin
            if (ev && eb) m_branches++;
            if (mis_exp) m_mispredicts++;
        end
        if (busy_exp) begin
            init_left--;
        end else if (ev && eb) begin
            ie = idx_of(epc);
            if (bt) model_cnt[ie] = (model_cnt[ie] < 3) ? model_cnt[ie] + 1 : 3;
            else    model_cnt[ie] = (model_cnt[ie] > 0) ? model_cnt[ie] - 1 : 0;
        end
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    endtask

    // Assert reset asynchronously, check held outputs, release; all training is lost.
    task automatic do_reset();
        reset_n = 1'b0;
        f_valid = 1'b1; f_pc = 32'h100;
        e_valid = 1'b1; e_branch = 1'b1; e_btaken = 1'b1; e_pred_taken = 1'b0; e_pc = 32'h100;
        #1;
        chk("rst_busy", {31'd0, bp_busy}, 32'd1);
        chk("rst_pred", {31'd0, f_pred_taken}, 32'd0);
        chk("rst_mispredict", {31'd0, e_mispredict}, 32'd0);
`ifdef BP_STATS_EN
        chk("rst_stat_br", stat_branches, 32'd0);
        chk("rst_stat_mis", stat_mispredicts, 32'd0);
`endif
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        for (int i = 0; i < 64; i++) model_cnt[i] = 1;
        init_left = 64;
        m_branches = 0; m_mispredicts = 0;
    endtask

    initial begin
        n_chk = 0; n_pass = 0;
        reset_n = 1'b1; stat_clr = 1'b0;
        f_valid = 0; f_pc = 0; e_valid = 0; e_branch = 0; e_pc = 0; e_btaken = 0; e_pred_taken = 0;
        @(posedge clk); #1;
        do_reset();

        // Init walk with fetch probing and EX updates that must be dropped.
        for (int i = 0; i < 64; i++)
            step(1'b1, $urandom, 1'b1, 1'b1, 32'h100, 1'b1, 1'b0);
        step(1'b1, 32'h100, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);

        // Saturate up then back down on 0x100.
        for (int i = 0; i < 4; i++) step(1'b1, 32'h100, 1'b1, 1'b1, 32'h100, 1'b1, 1'b0);
        for (int i = 0; i < 2; i++) step(1'b1, 32'h100, 1'b1, 1'b1, 32'h100, 1'b0, 1'b1);
        step(1'b1, 32'h100, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        chk("cnt_back_to_01_pred", {31'd0, f_pred_taken}, 32'd0);

        // Invalid EX with branch data: flag low, table untouched.
        step(1'b1, 32'h100, 1'b0, 1'b1, 32'h100, 1'b1, 1'b0);
        // Same-index collision and aliasing/masking (0x200, 0x202, 0x300, 0x104).
        step(1'b1, 32'h200, 1'b1, 1'b1, 32'h200, 1'b1, 1'b0);
        step(1'b1, 32'h202, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        step(1'b1, 32'h300, 1'b1, 1'b1, 32'h104, 1'b1, 1'b0);
        step(1'b1, 32'h104, 1'b1, 1'b1, 32'h104, 1'b1, 1'b0);
        step(1'b1, 32'h107, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);

        // Reset in RUN after training, then again at init_ptr=20.
        for (int i = 0; i < 3; i++) step(1'b1, 32'h100, 1'b1, 1'b1, 32'h100, 1'b1, 1'b1);
        do_reset();
        for (int i = 0; i < 20; i++) step(1'b1, 32'h100, 1'b1, 1'b1, 32'h100, 1'b1, 1'b0);
        do_reset();
        for (int i = 0; i < 64; i++) step(1'b1, 32'h100, 1'b1, 1'b1, 32'h100, 1'b1, 1'b0);
        step(1'b1, 32'h100, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);

`ifdef BP_STATS_EN
        // 10 branches, 3 mispredicted, then clear against a mispredict cycle.
        stat_clr = 1'b1; idle(1); stat_clr = 1'b0;
        for (int i = 0; i < 10; i++)
            step(1'b0, 32'h0, 1'b1, 1'b1, 32'h40, 1'b0, (i < 3) ? 1'b1 : 1'b0);
        idle(1);
        chk("stat_br_10", stat_branches, 32'd10);
        chk("stat_mis_3", stat_mispredicts, 32'd3);
        stat_clr = 1'b1;
        step(1'b0, 32'h0, 1'b1, 1'b1, 32'h40, 1'b1, 1'b0);
        stat_clr = 1'b0;
        idle(1);
        chk("stat_clr_br", stat_branches, 32'd0);
        chk("stat_clr_mis", stat_mispredicts, 32'd0);
`endif

        // Random traffic over a handful of indices with random upper PC bits.
        for (int i = 0; i < 800; i++) begin
            logic [31:0] fpc;
            logic [31:0] epc;
            fpc = ($urandom & 32'hFFFF_FF03) | (32'($urandom_range(0, 5)) << 2);
            epc = ($urandom & 32'hFFFF_FF03) | (32'($urandom_range(0, 5)) << 2);
            stat_clr = ($urandom_range(0, 49) == 0);
            step($urandom_range(0, 3) != 0, fpc, $urandom_range(0, 3) != 0,
                 $urandom_range(0, 2) != 0, epc, $urandom_range(0, 2) != 0, 1'($urandom));
            if (i == 400) begin
                stat_clr = 1'b0;
                do_reset();
            end
        end
        stat_clr = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/branch_history_predictor.md
Name: branch_history_predictor

Overview:
- 2-bit saturating-counter branch history table (BHT) for the 6-stage pipeline.
- Fetch stage gets a taken/not-taken prediction per PC. EX stage feeds back the resolved outcome from the branch condition logic (funct3 + N/Z/C/V -> Btaken). The table is trained with that outcome and a mispredict is flagged.
- Contains an init FSM that walks the table after reset, so the counter array needs no async reset.

Parameters:
- IDX_W, 6, table index width; table depth = 2**IDX_W entries.
- XLEN, 32, PC width.
- INIT_CNT, 2'b01, counter value written during init (weakly not-taken).

Ports:
- clk  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous active-low reset.
- f_valid  input  1  fetch PC valid.
- f_pc  input  XLEN  fetch PC.
- f_pred_taken  output  1  prediction for f_pc.
- e_valid  input  1  EX-stage instruction valid (not bubbled or flushed).
- e_branch  input  1  EX instruction is a conditional branch (the Branch control bit).
- e_pc  input  XLEN  PC of the EX instruction.
- e_btaken  input  1  resolved outcome from the branch condition logic.
- e_pred_taken  input  1  prediction carried down the pipe with this instruction.
- e_mispredict  output  1  resolved outcome differs from the prediction.
- bp_busy  output  1  init walk in progress.

Behaviour:
- Index: idx = pc[IDX_W+1:2] for both f_pc and e_pc. pc[1:0] is ignored.
- Storage: 2**IDX_W x 2-bit counter array, no reset on the array itself.
- FSM states:
  - INIT: entered asynchronously on reset_n=0. init_ptr resets to 0. Each cycle writes INIT_CNT to entry init_ptr, then increments init_ptr. When init_ptr = 2**IDX_W-1 is written, the next state is RUN. bp_busy=1 throughout. INIT lasts exactly 2**IDX_W cycles after reset release.
  - RUN: normal operation. bp_busy=0. No exit except reset.
- Reset values: bp_busy=1, init_ptr=0, state=INIT. f_pred_taken=0 and e_mispredict=0 while reset is asserted.
- Prediction (combinational, 0 latency):
  - f_pred_taken = f_valid & ~bp_busy & cnt[idx_f][1].
  - During INIT the prediction is forced to 0.
- Mispredict (combinational):
  - e_mispredict = e_valid & e_branch & (e_btaken != e_pred_taken).
  - Valid in INIT too, so the pipeline can still flush correctly; the predictor only ever said not-taken during INIT.
- Update, registered at the rising clk edge, when state=RUN & e_valid & e_branch:
  - e_btaken=1: cnt <= (cnt==2'b11) ? 2'b11 : cnt+1.
  - e_btaken=0: cnt <= (cnt==2'b00) ? 2'b00 : cnt-1.
  - Saturating at both ends; never wraps.
- Updates during INIT are dropped. Only the init write occurs.
- Same-cycle read and update of the same idx: the prediction uses the old (pre-update) value. No bypass.
- Aliasing: PCs with equal idx share a counter. No tag check.
- Non-branch or invalid EX instructions never modify the table.
- Reset mid-operation, including mid-INIT: the FSM restarts INIT from entry 0 and all prior training is lost.

Optional Feature:
- Macro: BP_STATS_EN.
- When defined, adds ports stat_clr (input, 1), stat_branches (output, 32) and stat_mispredicts (output, 32).
  - stat_branches counts RUN-state updates.
  - stat_mispredicts counts cycles with e_mispredict=1 in RUN.
  - Both reset to 0 asynchronously and clear synchronously on stat_clr. stat_clr wins over a same-cycle increment.
  - Both wrap modulo 2**32.
- When undefined, the ports and counters are absent and the behaviour is otherwise identical.

Test Plan:
- Init walk: release reset_n, IDX_W=6 -> bp_busy=1 for exactly 64 cycles, then 0. f_pred_taken=0 for any f_pc during INIT. Afterwards f_pc=0x100 -> f_pred_taken=0 (counter 01).
- Saturate up: e_pc=0x100, e_branch=1, e_btaken=1 for 4 cycles -> counter goes 01->10->11->11. f_pc=0x100 predicts 1 from the cycle after the first update. Two not-taken updates -> 11->10->01, prediction returns to 0.
- Mispredict flag: e_valid=1, e_branch=1, e_btaken=1, e_pred_taken=0 -> e_mispredict=1 in the same cycle. The same stimulus with e_valid=0 -> 0 and no table change.
- Same-index collision: f_pc=0x200 and e_pc=0x200 updating taken from 01 in the same cycle -> f_pred_taken=0 that cycle and 1 the next. e_pc=0x300 (idx 0, aliasing 0x200 only if the index matches) verifies index masking. Also verify f_pc=0x202 maps to the same entry as 0x200.
- Reset mid-operation: train entry 0x100 to 11, pulse reset_n low during RUN and again at init_ptr=20 -> bp_busy restarts with a full 64-cycle walk. Entry 0x100 then predicts 0. EX updates issued during INIT leave the counters at 01.
- BP_STATS_EN: 10 branches with 3 mispredicts -> stat_branches=10, stat_mispredicts=3. stat_clr together with a mispredict cycle -> both counters 0.
